// File: rtl/axi_mem_slave_p_if.sv
// axi_mem_slave_p_if: parametrised AXI4 bundle between a test master and the memory slave
interface axi_mem_slave_p_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_mem_slave_p.sv
// axi_mem_slave_p: AXI4 slave memory model with burst sequencing, read latency, error responses and stalls
module axi_mem_slave_p #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ID_WIDTH     = 6,
    parameter int                    MEM_WORDS    = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    axi_mem_slave_p_if.slave    axi,
    input  logic                rd_stall,
    input  logic                wr_stall,
    output logic                rd_busy,
    output logic                wr_busy,
    output logic [15:0]         err_count
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LG = $clog2(NB);
    localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // WRAP keeps the bits above the wrap window and lets the low bits roll over
    function automatic addr_t next_addr(addr_t a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        addr_t inc, msk;
        inc = addr_t'(1) << size;
        msk = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~msk) | ((a + inc) & msk) : a + inc;
    endfunction

    function automatic logic legal(logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        return burst != 2'b11 && 32'(size) <= LG &&
               (burst != 2'b10 || len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

    function automatic logic in_range(addr_t a);
        return a >= BASE_ADDR && ((a - BASE_ADDR) >> LG) < addr_t'(MEM_WORDS);
    endfunction

    function automatic logic [IW-1:0] idx(addr_t a);
        return IW'((a - BASE_ADDR) >> LG);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    r_state_e r_state_q, r_state_d;
    w_state_e w_state_q, w_state_d;
    addr_t r_addr_q, w_addr_q;
    logic [7:0] r_len_q, r_cnt_q, r_lat_q, w_len_q, w_cnt_q;
    logic [2:0] r_size_q, w_size_q;
    logic [1:0] r_burst_q, w_burst_q, rresp_q, w_resp_q, w_br;
    logic [ID_WIDTH-1:0] r_id_q, w_id_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic r_ok_q, w_ok_q, rvalid_q, rlast_q;
    logic arready, awready, wready, bvalid, r_load, w_hs;
    logic [15:0] err_q;
    logic [16:0] err_sum;

    always_ff @(posedge clk) begin
        r_state_q <= rst ? R_IDLE : r_state_d;
        w_state_q <= rst ? W_IDLE : w_state_d;
    end

    always_comb begin
        r_state_d = r_state_q == R_IDLE ? (axi.arvalid ? R_WAIT : R_IDLE) :
                    r_state_q == R_WAIT ? (r_lat_q == '0 ? R_BEAT : R_WAIT) :
                    (rvalid_q && axi.rready && rlast_q ? R_IDLE : R_BEAT);
        w_state_d = w_state_q == W_IDLE ? (axi.awvalid ? W_DATA : W_IDLE) :
                    w_state_q == W_DATA ? (w_hs && w_cnt_q == w_len_q ? W_RESP : W_DATA) :
                    (axi.bready ? W_IDLE : W_RESP);
    end

    always_comb begin
        arready = r_state_q == R_IDLE && !rst;
        rd_busy = r_state_q != R_IDLE;
        r_load  = !rd_stall && ((r_state_q == R_WAIT && r_lat_q == '0) ||
                  (r_state_q == R_BEAT && (!rvalid_q || (axi.rready && !rlast_q))));
        awready = w_state_q == W_IDLE && !rst;
        wready  = w_state_q == W_DATA && !wr_stall && !rst;
        w_hs    = axi.wvalid && wready;
        bvalid  = w_state_q == W_RESP;
        wr_busy = w_state_q != W_IDLE;
        w_br    = !w_ok_q ? 2'b10 : !in_range(w_addr_q) ? 2'b11 :
                  (axi.wlast != (w_cnt_q == w_len_q)) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
            r_ok_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            if (axi.arvalid && arready) begin
                r_addr_q  <= axi.araddr;
                r_len_q   <= axi.arlen;
                r_size_q  <= axi.arsize;
                r_burst_q <= axi.arburst;
                r_id_q    <= axi.arid;
                r_cnt_q   <= '0;
                r_lat_q   <= 8'(READ_LATENCY - 1);
                r_ok_q    <= legal(axi.arlen, axi.arsize, axi.arburst);
            end else if (r_state_q == R_WAIT && r_lat_q != '0) begin
                r_lat_q <= r_lat_q - 8'd1;
            end
            if (r_load) begin
                rvalid_q <= 1'b1;
                rlast_q  <= r_cnt_q == r_len_q;
                rdata_q  <= r_ok_q && in_range(r_addr_q) ? mem[idx(r_addr_q)] : '0;
                rresp_q  <= !r_ok_q ? 2'b10 : in_range(r_addr_q) ? 2'b00 : 2'b11;
                r_cnt_q  <= r_cnt_q + 8'd1;
                r_addr_q <= next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
            end else if (rvalid_q && axi.rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_cnt_q   <= '0;
            w_ok_q    <= 1'b0;
            w_resp_q  <= '0;
        end else if (axi.awvalid && awready) begin
            w_addr_q  <= axi.awaddr;
            w_len_q   <= axi.awlen;
            w_size_q  <= axi.awsize;
            w_burst_q <= axi.awburst;
            w_id_q    <= axi.awid;
            w_cnt_q   <= '0;
            w_ok_q    <= legal(axi.awlen, axi.awsize, axi.awburst);
            w_resp_q  <= '0;
        end else if (w_hs) begin
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
            w_resp_q <= w_br > w_resp_q ? w_br : w_resp_q;
        end
    end

    // backing store is never reset so contents survive a mid-test reset
    always_ff @(posedge clk) begin
        if (w_hs && w_ok_q && in_range(w_addr_q))
            for (int b = 0; b < NB; b++)
                if (axi.wstrb[b]) mem[idx(w_addr_q)][8*b +: 8] <= axi.wdata[8*b +: 8];
    end

    assign err_sum = 17'(err_q) + 17'(rvalid_q && axi.rready && rresp_q != 2'b00)
                   + 17'(bvalid && axi.bready && w_resp_q != 2'b00);

    always_ff @(posedge clk) begin
        err_q <= rst ? 16'd0 : err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign axi.arready = arready;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = r_id_q;
    assign axi.awready = awready;
    assign axi.wready  = wready;
    assign axi.bvalid  = bvalid;
    assign axi.bresp   = w_resp_q;
    assign axi.bid     = w_id_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_axi_mem_slave_p.sv
// tb_axi_mem_slave_p: directed self-checking bench for the AXI slave memory model
module tb_axi_mem_slave_p;
    logic clk = 1'b0, rst = 1'b1, rd_stall = 1'b0, wr_stall = 1'b0;
    logic rd_busy, wr_busy;
    logic [15:0] err_count;
    int checks = 0, failures = 0, cyc = 0;
    bit rand_bp = 1'b0;
    logic [31:0] rd_data [64];
    logic [1:0]  rd_resp [64];
    logic        rd_last [64];
    logic [5:0]  rd_id   [64];
    int          rd_lat;
    logic [1:0]  bresp, bresp2;
    logic [5:0]  bid, bid2;
    logic [31:0] wrap_exp [4];

    axi_mem_slave_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(6)) axi ();

    axi_mem_slave_p #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(6),
        .MEM_WORDS(256), .BASE_ADDR(32'h0), .READ_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst), .axi(axi), .rd_stall(rd_stall), .wr_stall(wr_stall),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready/stall driver: fully open unless random backpressure is enabled
    initial forever begin
        @(posedge clk);
        #1;
        axi.rready = rand_bp ? 1'($urandom) : 1'b1;
        axi.bready = rand_bp ? 1'($urandom) : 1'b1;
        rd_stall   = rand_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
        wr_stall   = rand_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    // a stalled R beat must hold its payload until accepted
    initial begin
        logic hold = 1'b0, hl = 1'b0;
        logic [31:0] hd = '0;
        logic [1:0]  hr = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                check("r_hold_valid", axi.rvalid, 1);
                check("r_hold_data", axi.rdata, hd);
                check("r_hold_resp", axi.rresp, hr);
                check("r_hold_last", axi.rlast, hl);
            end
            hold = !rst && axi.rvalid && !axi.rready;
            hd = axi.rdata;
            hr = axi.rresp;
            hl = axi.rlast;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0, t = 0, first = -1, ar_edge;
        @(posedge clk);
        #1;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2;
        axi.arburst = burst; axi.arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (axi.arready) break;
            if (++t > 200) begin check("ar_timeout", 0, 1); break; end
        end
        ar_edge = cyc + 1;
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        t = 0;
        while (n <= int'(len)) begin
            @(negedge clk);
            if (axi.rvalid && first < 0) first = cyc;
            if (axi.rvalid && axi.rready) begin
                rd_data[n] = axi.rdata; rd_resp[n] = axi.rresp;
                rd_last[n] = axi.rlast; rd_id[n] = axi.rid;
                n++;
            end
            if (++t > 400) begin check("r_timeout", 0, 1); break; end
        end
        rd_lat = first - ar_edge;
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] pat, input logic [3:0] strb,
                            input int bad, output logic [1:0] resp, output logic [5:0] b_id);
        int t = 0;
        @(posedge clk);
        #1;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
        axi.awburst = burst; axi.awvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (axi.awready) break;
            if (++t > 200) begin check("aw_timeout", 0, 1); break; end
        end
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.wvalid = 1'b1; axi.wdata = pat + 32'(i); axi.wstrb = strb;
            axi.wlast = bad < 0 ? i == int'(len) : i == bad;
            t = 0;
            forever begin
                @(negedge clk);
                if (axi.wready) break;
                if (++t > 200) begin check("w_timeout", 0, 1); break; end
            end
            @(posedge clk);
            #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (axi.bvalid && axi.bready) break;
            if (++t > 200) begin check("b_timeout", 0, 1); break; end
        end
        resp = axi.bresp;
        b_id = axi.bid;
    endtask

    initial begin
        axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.rready = 1'b1; axi.bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", axi.arready, 0);
        check("rst_awready", axi.awready, 0);
        check("rst_wready", axi.wready, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rlast", axi.rlast, 0);
        check("rst_rdata", axi.rdata, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_err", err_count, 0);
        check("rst_busy", {rd_busy, wr_busy}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_arready", axi.arready, 1);
        check("idle_awready", axi.awready, 1);

        do_write(6'h15, 32'h100, 8'd3, 2'b01, 32'hA0, 4'hF, -1, bresp, bid);
        check("incr_w_bresp", bresp, 0);
        check("incr_w_bid", bid, 6'h15);
        do_read(6'h2A, 32'h100, 8'd3, 2'b01);
        check("incr_r_lat", rd_lat, 3);
        check("incr_r_rid", rd_id[0], 6'h2A);
        for (int i = 0; i < 4; i++) begin
            check("incr_r_data", rd_data[i], 32'hA0 + 32'(i));
            check("incr_r_resp", rd_resp[i], 0);
            check("incr_r_last", rd_last[i], i == 3);
        end

        wrap_exp = '{32'hA3, 32'hA0, 32'hA1, 32'hA2};
        do_read(6'h01, 32'h10C, 8'd3, 2'b10);
        for (int i = 0; i < 4; i++) check("wrap_r_data", rd_data[i], wrap_exp[i]);
        do_read(6'h02, 32'h100, 8'd2, 2'b00);
        for (int i = 0; i < 3; i++) check("fixed_r_data", rd_data[i], 32'hA0);
        check("fixed_r_last", {rd_last[0], rd_last[1], rd_last[2]}, 3'b001);

        do_write(6'h03, 32'h180, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF, -1, bresp, bid);
        do_write(6'h03, 32'h180, 8'd0, 2'b01, 32'h0, 4'h5, -1, bresp, bid);
        do_read(6'h03, 32'h180, 8'd0, 2'b01);
        check("strb_r_data", rd_data[0], 32'hFF00_FF00);

        do_read(6'h04, 32'h400, 8'd0, 2'b01);
        check("oor_r_resp", rd_resp[0], 2'b11);
        check("oor_r_data", rd_data[0], 0);
        do_read(6'h05, 32'h100, 8'd3, 2'b11);
        for (int i = 0; i < 4; i++) check("bad_burst_r_resp", rd_resp[i], 2'b10);
        do_write(6'h06, 32'h140, 8'd3, 2'b01, 32'h55, 4'hF, 1, bresp, bid);
        check("wlast_w_bresp", bresp, 2'b10);
        do_write(6'h07, 32'h100, 8'd0, 2'b11, 32'hDEAD, 4'hF, -1, bresp, bid);
        check("bad_burst_w_bresp", bresp, 2'b10);
        do_read(6'h08, 32'h100, 8'd0, 2'b01);
        check("bad_burst_no_write", rd_data[0], 32'hA0);
        @(posedge clk);
        #1;
        check("err_count", err_count, 7);

        do_write(6'h09, 32'h200, 8'd15, 2'b01, 32'h1000, 4'hF, -1, bresp, bid);
        check("pre_w_bresp", bresp, 0);
        rand_bp = 1'b1;
        fork
            do_read(6'h0A, 32'h200, 8'd15, 2'b01);
            do_write(6'h0B, 32'h300, 8'd15, 2'b01, 32'h2000, 4'hF, -1, bresp2, bid2);
        join
        rand_bp = 1'b0;
        check("bp_w_bresp", bresp2, 0);
        check("bp_w_bid", bid2, 6'h0B);
        for (int i = 0; i < 16; i++) begin
            check("bp_r_data", rd_data[i], 32'h1000 + 32'(i));
            check("bp_r_resp", rd_resp[i], 0);
            check("bp_r_last", rd_last[i], i == 15);
        end
        do_read(6'h0C, 32'h300, 8'd15, 2'b01);
        for (int i = 0; i < 16; i++) check("bp_wb_data", rd_data[i], 32'h2000 + 32'(i));
        @(posedge clk);
        #1;
        check("bp_err_count", err_count, 7);

        begin
            int n = 0, t = 0;
            axi.arid = 6'h0D; axi.araddr = 32'h200; axi.arlen = 8'd7; axi.arsize = 3'd2;
            axi.arburst = 2'b01; axi.arvalid = 1'b1;
            forever begin
                @(negedge clk);
                if (axi.arready) break;
                if (++t > 200) begin check("rst_ar_timeout", 0, 1); break; end
            end
            @(posedge clk);
            #1 axi.arvalid = 1'b0;
            t = 0;
            forever begin
                @(negedge clk);
                if (axi.rvalid && n == 1) break;
                if (axi.rvalid && axi.rready) n++;
                if (++t > 200) begin check("rst_r_timeout", 0, 1); break; end
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("midrst_rvalid", axi.rvalid, 0);
            check("midrst_rd_busy", rd_busy, 0);
            check("midrst_err", err_count, 0);
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("midrst_no_beat", axi.rvalid, 0);
            end
        end
        do_read(6'h0E, 32'h204, 8'd0, 2'b01);
        check("post_rst_data", rd_data[0], 32'h1001);
        check("post_rst_rid", rd_id[0], 6'h0E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
